fb_arbiter: RTL and testbench

Frame-buffer arbiter between the VGA sync timing generator and a single-port synchronous pixel RAM. It uses the sync block's 25 MHz `tick`, `pixel_x`, `pixel_y` and `video_on` to fetch one display pixel per pixel period at guaranteed priority. Every other RAM cycle goes to one pixel-manipulation client through a req/gnt handshake. It sits between the sync generator, the pixel RAM and the RGB output pins.

---
 rtl/fb_pkg.sv | 16 +
 rtl/fb_addr_gen.sv | 32 +++
 rtl/fb_arbiter.sv | 138 +++++++++++++
 tb/tb_fb_arbiter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared constants and slot encoding for the frame-buffer arbiter.
package fb_pkg;

    localparam int H_ACTIVE       = 640;
    localparam int V_ACTIVE       = 480;
    localparam int DATA_W_DEFAULT = 12;
    localparam int ADDR_W_DEFAULT = 19;

    typedef enum logic [1:0] {
        DISP = 2'd0,
        C1   = 2'd1,
        C2   = 2'd2,
        C3   = 2'd3
    } slot_t;

endpackage

// File: rtl/fb_addr_gen.sv
// Pixel coordinate to linear frame-buffer address.
// FB_ARB_HALF_RES_EN selects a 320x240 buffer shown as 2x2 blocks.
module fb_addr_gen
    import fb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT
) (
    input  logic [9:0]        pixel_x,
    input  logic [9:0]        pixel_y,
    output logic [ADDR_W-1:0] addr
);

    logic [19:0] lin_s;

`ifdef FB_ARB_HALF_RES_EN
    logic [8:0] x_half_s;
    logic [8:0] y_half_s;
    logic       unused_s;

    assign x_half_s = pixel_x[9:1];
    assign y_half_s = pixel_y[9:1];
    // y*320 as (y<<8)+(y<<6); the dropped LSBs are what makes each word a 2x2 block
    assign lin_s    = ({11'd0, y_half_s} << 8) + ({11'd0, y_half_s} << 6) + {11'd0, x_half_s};
    assign unused_s = ^{pixel_x[0], pixel_y[0]};
`else
    // y*640 as (y<<9)+(y<<7); 20 bits holds the largest 10-bit coordinate pair
    assign lin_s = ({10'd0, pixel_y} << 9) + ({10'd0, pixel_y} << 7) + {10'd0, pixel_x};
`endif

    assign addr = ADDR_W'(lin_s);

endmodule

// File: rtl/fb_arbiter.sv
// Frame-buffer arbiter: display fetch owns the DISP slot during active video,
// the client gets all other RAM cycles. Option macro: FB_ARB_HALF_RES_EN.
module fb_arbiter
    import fb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int ADDR_W = ADDR_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick,
    input  logic              video_on,
    input  logic [9:0]        pixel_x,
    input  logic [9:0]        pixel_y,
    input  logic              cl_req,
    input  logic              cl_we,
    input  logic [ADDR_W-1:0] cl_addr,
    input  logic [DATA_W-1:0] cl_wdata,
    output logic              cl_gnt,
    output logic              cl_rvalid,
    output logic [DATA_W-1:0] cl_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] rgb
);

    slot_t             state_r;
    slot_t             state_nxt_s;
    logic [ADDR_W-1:0] disp_addr_s;
    logic              disp_fetch_s;
    logic              cl_rd_s;
    logic              rd_pend_r;
    logic              rd_client_r;
    logic              blank_r;
    logic [DATA_W-1:0] rgb_r;
    logic [DATA_W-1:0] cl_rdata_r;
    logic              cl_rvalid_r;

    fb_addr_gen #(
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .pixel_x (pixel_x),
        .pixel_y (pixel_y),
        .addr    (disp_addr_s)
    );

    // Slot sequencing; tick forces realignment so the next cycle is always DISP
    always_comb begin
        state_nxt_s = DISP;
        if (tick) begin
            state_nxt_s = DISP;
        end else begin
            case (state_r)
                DISP:    state_nxt_s = C1;
                C1:      state_nxt_s = C2;
                C2:      state_nxt_s = C3;
                C3:      state_nxt_s = DISP;
                default: state_nxt_s = DISP;
            endcase
        end
    end

    // Slot state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= DISP;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // RAM port mux: display fetch wins DISP during active video, otherwise client
    always_comb begin
        disp_fetch_s = 1'b0;
        cl_gnt       = 1'b0;
        mem_en       = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        if (reset) begin
            disp_fetch_s = 1'b0;
            cl_gnt       = 1'b0;
        end else if ((state_r == DISP) && video_on) begin
            disp_fetch_s = 1'b1;
            mem_en       = 1'b1;
            mem_addr     = disp_addr_s;
        end else if (cl_req) begin
            cl_gnt    = 1'b1;
            mem_en    = 1'b1;
            mem_we    = cl_we;
            mem_addr  = cl_addr;
            mem_wdata = cl_wdata;
        end else begin
            mem_en = 1'b0;
            mem_we = 1'b0;
        end
    end

    assign cl_rd_s = cl_gnt & ~cl_we;

    // Read-return tagging and registered display/client outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_pend_r   <= 1'b0;
            rd_client_r <= 1'b0;
            blank_r     <= 1'b0;
            rgb_r       <= '0;
            cl_rdata_r  <= '0;
            cl_rvalid_r <= 1'b0;
        end else begin
            rd_pend_r   <= disp_fetch_s | cl_rd_s;
            rd_client_r <= cl_rd_s;
            blank_r     <= (state_r == DISP) & ~video_on;
            cl_rvalid_r <= rd_pend_r & rd_client_r;
            if (rd_pend_r && rd_client_r) begin
                cl_rdata_r <= mem_rdata;
            end else begin
                cl_rdata_r <= cl_rdata_r;
            end
            // a client read in a blanked DISP slot still blanks the pixel
            if (rd_pend_r && !rd_client_r) begin
                rgb_r <= mem_rdata;
            end else if (blank_r) begin
                rgb_r <= '0;
            end else begin
                rgb_r <= rgb_r;
            end
        end
    end

    assign rgb       = rgb_r;
    assign cl_rdata  = cl_rdata_r;
    assign cl_rvalid = cl_rvalid_r;

endmodule

// File: tb/tb_fb_arbiter.sv
// Randomised self-checking bench for fb_arbiter against a slot/phase reference model.
`timescale 1ns/1ps
module tb_fb_arbiter;

    localparam int DW = 12;
    localparam int AW = 19;
    localparam int MEM_WORDS = 1 << AW;

    logic          clk = 1'b0;
    logic          reset;
    logic          tick;
    logic          video_on;
    logic [9:0]    pixel_x;
    logic [9:0]    pixel_y;
    logic          cl_req;
    logic          cl_we;
    logic [AW-1:0] cl_addr;
    logic [DW-1:0] cl_wdata;
    logic          cl_gnt;
    logic          cl_rvalid;
    logic [DW-1:0] cl_rdata;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic [DW-1:0] rgb;

    always #5 clk = ~clk;

    fb_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .tick      (tick),
        .video_on  (video_on),
        .pixel_x   (pixel_x),
        .pixel_y   (pixel_y),
        .cl_req    (cl_req),
        .cl_we     (cl_we),
        .cl_addr   (cl_addr),
        .cl_wdata  (cl_wdata),
        .cl_gnt    (cl_gnt),
        .cl_rvalid (cl_rvalid),
        .cl_rdata  (cl_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .rgb       (rgb)
    );

    function automatic logic [DW-1:0] init_word(input int a);
        return DW'(a * 37 + 961);
    endfunction

    // Pixel RAM with 1-cycle read latency; unwritten words hold init_word
    logic [DW-1:0] ram    [0:MEM_WORDS-1];
    bit            ram_wr [0:MEM_WORDS-1];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                ram[int'(mem_addr)]    <= mem_wdata;
                ram_wr[int'(mem_addr)] <= 1'b1;
            end else begin
                mem_rdata <= ram_wr[int'(mem_addr)] ? ram[int'(mem_addr)] : init_word(int'(mem_addr));
            end
        end
    end

    // Reference model state
    logic [DW-1:0] ref_mem [0:MEM_WORDS-1];
    bit            ref_wr  [0:MEM_WORDS-1];
    int            m_phase = 0;
    bit            m_ret_valid = 1'b0, m_ret_client = 1'b0, m_blank = 1'b0;
    logic [DW-1:0] m_ret_data = '0;
    logic [DW-1:0] e_rgb = '0, e_rdata = '0;
    bit            e_rvalid = 1'b0;
    bit            e_disp, e_gnt, e_en, e_we;
    logic [AW-1:0] e_addr;

    typedef struct {
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } acc_t;
    acc_t cq[$];

    bit force_tick = 1'b0;
    bit chk_on     = 1'b0;
    int gnt_seen   = 0;
    int n_checks   = 0;
    int n_errors   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [AW-1:0] disp_addr(input int x, input int y);
`ifdef FB_ARB_HALF_RES_EN
        return AW'((y / 2) * 320 + x / 2);
`else
        return AW'(y * 640 + x);
`endif
    endfunction

    // One clock: drive inputs, check at negedge, advance the model at posedge
    task automatic step();
        tick = force_tick || (m_phase == 3);
        if (cq.size() > 0) begin
            cl_req   = 1'b1;
            cl_we    = cq[0].we;
            cl_addr  = cq[0].addr;
            cl_wdata = cq[0].wdata;
        end else begin
            cl_req   = 1'b0;
            cl_we    = 1'b0;
            cl_addr  = '0;
            cl_wdata = '0;
        end
        e_disp = !reset && (m_phase == 0) && video_on;
        e_gnt  = !reset && !e_disp && cl_req;
        e_en   = e_disp || e_gnt;
        e_we   = e_gnt && cl_we;
        e_addr = e_disp ? disp_addr(int'(pixel_x), int'(pixel_y)) : cl_addr;
        @(negedge clk);
        if (cl_gnt === 1'b1) gnt_seen++;
        if (chk_on) begin
            check_eq("mem_en", 32'(mem_en), 32'(e_en));
            check_eq("mem_we", 32'(mem_we), 32'(e_we));
            check_eq("cl_gnt", 32'(cl_gnt), 32'(e_gnt));
            if (e_en) check_eq("mem_addr", 32'(mem_addr), 32'(e_addr));
            if (e_we) check_eq("mem_wdata", 32'(mem_wdata), 32'(cl_wdata));
            if (reset) begin
                check_eq("rst_mem_addr", 32'(mem_addr), 32'd0);
                check_eq("rst_mem_wdata", 32'(mem_wdata), 32'd0);
            end
            check_eq("rgb", 32'(rgb), 32'(e_rgb));
            check_eq("cl_rvalid", 32'(cl_rvalid), 32'(e_rvalid));
            check_eq("cl_rdata", 32'(cl_rdata), 32'(e_rdata));
        end
        @(posedge clk);
        if (reset) begin
            e_rgb = '0; e_rdata = '0; e_rvalid = 1'b0;
            m_ret_valid = 1'b0; m_ret_client = 1'b0; m_blank = 1'b0;
            cq.delete();
            m_phase = 0;
        end else begin
            e_rvalid = m_ret_valid && m_ret_client;
            if (m_ret_valid && m_ret_client) e_rdata = m_ret_data;
            if (m_ret_valid && !m_ret_client) e_rgb = m_ret_data;
            else if (m_blank) e_rgb = '0;
            m_ret_valid  = e_disp || (e_gnt && !cl_we);
            m_ret_client = e_gnt && !cl_we;
            m_ret_data   = ref_wr[int'(e_addr)] ? ref_mem[int'(e_addr)] : init_word(int'(e_addr));
            m_blank      = (m_phase == 0) && !video_on;
            if (e_gnt && cl_we) begin
                ref_mem[int'(cl_addr)] = cl_wdata;
                ref_wr[int'(cl_addr)]  = 1'b1;
            end
            if (e_gnt) void'(cq.pop_front());
            m_phase = tick ? 0 : (m_phase + 1) % 4;
        end
        #1;
    endtask

    task automatic align();
        for (int i = 0; i < 8 && m_phase != 0; i++) step();
    endtask

    task automatic push(input bit we, input int addr, input int wdata);
        acc_t a;
        a.we = we; a.addr = AW'(addr); a.wdata = DW'(wdata);
        cq.push_back(a);
    endtask

    initial begin
        reset = 1'b1; tick = 1'b0; video_on = 1'b0; pixel_x = '0; pixel_y = '0;
        cl_req = 1'b0; cl_we = 1'b0; cl_addr = '0; cl_wdata = '0;
        @(posedge clk); #1;
        chk_on = 1'b1;
        // reset values, including a request that must not be granted
        push(1'b1, 7, 7);
        step();
        step();
        reset = 1'b0;

        // blanking then active video with no client traffic
        for (int i = 0; i < 8; i++) step();
        video_on = 1'b1; pixel_x = 10'd10; pixel_y = 10'd3;
        for (int i = 0; i < 8; i++) step();

        // seed word 1285 during blanking, then display pixel (5,2)
        video_on = 1'b0;
        push(1'b1, 1285, 12'hABC);
        for (int i = 0; i < 4; i++) step();
        align();
        video_on = 1'b1; pixel_x = 10'd5; pixel_y = 10'd2;
        for (int i = 0; i < 8; i++) step();

        // client write/read during active video
        push(1'b1, 100, 12'h123);
        push(1'b0, 100, 0);
        for (int i = 0; i < 12; i++) step();

        // full client bandwidth during blanking
        video_on = 1'b0;
        for (int i = 0; i < 8; i++) push(i % 2 == 0, 200 + i, 16 * i + 5);
        align();
        gnt_seen = 0;
        for (int i = 0; i < 4; i++) step();
        check_eq("blank_gnts", 32'(gnt_seen), 32'd4);
        for (int i = 0; i < 6; i++) step();

        // tick injected in C1
        video_on = 1'b1; pixel_x = 10'd33; pixel_y = 10'd20;
        align();
        step();
        force_tick = 1'b1;
        step();
        force_tick = 1'b0;
        for (int i = 0; i < 6; i++) step();

        // reset the cycle after a client read grant
        push(1'b0, 100, 0);
        for (int i = 0; i < 8 && cq.size() > 0; i++) step();
        check_eq("rd_granted", 32'(cq.size()), 32'd0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) step();

        // randomised traffic with occasional mis-phased ticks
        for (int n = 0; n < 800; n++) begin
            if (m_phase == 0) begin
                video_on = ($urandom % 4) != 0;
                pixel_x  = video_on ? 10'($urandom_range(0, 639)) : 10'($urandom_range(0, 799));
                pixel_y  = video_on ? 10'($urandom_range(0, 479)) : 10'($urandom_range(0, 524));
            end
            force_tick = ($urandom % 40) == 0;
            if (cq.size() < 2 && ($urandom % 3) == 0) begin
                if ($urandom % 2 == 0)
                    push($urandom % 2 == 0, int'(disp_addr(int'(pixel_x), int'(pixel_y))), int'($urandom));
                else
                    push($urandom % 2 == 0, int'($urandom_range(0, 3000)), int'($urandom));
            end
            step();
        end
        force_tick = 1'b0;
        cq.delete();
        for (int i = 0; i < 4; i++) step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
